// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : MEM-stage load/store sequencer with a data-memory req/ack
//                    handshake, byte-lane steering and load-data extension.
// Optional feature : MEM_TIMEOUT_EN enables the ACCESS-cycle timeout abort.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        M_MemRead,
  input  logic        M_MemWrite,
  input  logic [1:0]  M_Size,
  input  logic        M_Unsigned,
  input  logic [31:0] M_Addr,
  input  logic [31:0] M_StoreData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] M_MemData,
  output logic        mem_stall,
  output logic        M_AddrErr,
  output logic        M_BusErr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]  state;
  logic        mem_op;
  logic        misaligned;
  logic        start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        timeout_hit;

  assign mem_op     = M_MemWrite | M_MemRead;
  assign misaligned = ((M_Size == 2'b01) && M_Addr[0]) ||
                      (M_Size[1] && (M_Addr[1:0] != 2'b00));
  assign start      = (state == IDLE) && mem_op && !misaligned;

  assign M_AddrErr  = !reset && (state == IDLE) && mem_op && misaligned;
  assign mem_stall  = !reset && (start || (state == ACCESS));

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = M_StoreData;
    case (M_Size)
      2'b00: begin
        be_next    = 4'b0001 << M_Addr[1:0];
        wdata_next = {4{M_StoreData[7:0]}};
      end
      2'b01: begin
        be_next    = M_Addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{M_StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lanes come from the address latched at IDLE exit, not the live bus.
  always_comb begin
    byte_sel  = dmem_rdata[7:0];
    half_sel  = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (lane_q)
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      2'd3:    byte_sel = dmem_rdata[31:24];
      default: ;
    endcase
    case (size_q)
      2'b00:   load_data = {{24{!unsigned_q && byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{!unsigned_q && half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;

  // Counter value k marks the (k+1)-th ACCESS cycle; abort at the end of cycle TIMEOUT.
  assign timeout_hit = (state == ACCESS) && !dmem_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign M_BusErr    = bus_err_q && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
      if (start)
        wait_cnt <= '0;
      else if ((state == ACCESS) && !dmem_ack)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign M_BusErr       = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      M_MemData  <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCESS;
            dmem_req   <= 1'b1;
            dmem_we    <= M_MemWrite;
            dmem_addr  <= {M_Addr[31:2], 2'b00};
            dmem_be    <= be_next;
            dmem_wdata <= wdata_next;
            lane_q     <= M_Addr[1:0];
            size_q     <= M_Size;
            unsigned_q <= M_Unsigned;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            dmem_be  <= '0;
            if (!dmem_we)
              M_MemData <= load_data;
          end else if (timeout_hit) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            if (!dmem_we)
              M_MemData <= 32'hDEADBEEF;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : directed + randomized self-checking bench for
//                       mem_access_stage against a behavioural access model.
// Revision            : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_stage;

  localparam int TB_TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        M_MemRead, M_MemWrite, M_Unsigned;
  logic [1:0]  M_Size;
  logic [31:0] M_Addr, M_StoreData;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, M_MemData;
  logic [3:0]  dmem_be;
  logic        mem_stall, M_AddrErr, M_BusErr;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_mem;

  always #5 clock = ~clock;

  mem_access_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_Size(M_Size),
    .M_Unsigned(M_Unsigned), .M_Addr(M_Addr), .M_StoreData(M_StoreData),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .M_MemData(M_MemData), .mem_stall(mem_stall),
    .M_AddrErr(M_AddrErr), .M_BusErr(M_BusErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: lane rules expressed as plain arithmetic.
  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    int lane;
    lane = int'(a % 4);
    if (sz == 2'b00) return 4'(1 << lane);
    if (sz == 2'b01) return (lane >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'b01) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Entered and left on a falling edge with the DUT idle.
  task automatic run_access(input logic wr, input logic rd, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rdat, input int waits);
    int stalls;
    stalls      = 0;
    M_MemWrite  = wr;
    M_MemRead   = rd;
    M_Size      = sz;
    M_Unsigned  = uns;
    M_Addr      = a;
    M_StoreData = sd;
    #1;
    chk("addrerr_aligned", M_AddrErr, 0);
    if (mem_stall) stalls++;
    @(negedge clock);
    chk("req_start", dmem_req, 1);
    chk("we", dmem_we, wr);
    chk("addr", dmem_addr, a & 32'hFFFF_FFFC);
    chk("be", dmem_be, ref_be(sz, a));
    if (wr) chk("wdata", dmem_wdata, ref_wdata(sz, sd));
    for (int w = 0; w <= waits; w++) begin
      if (mem_stall) stalls++;
      chk("req_held", dmem_req, 1);
      chk("addr_held", dmem_addr, a & 32'hFFFF_FFFC);
      chk("be_held", dmem_be, ref_be(sz, a));
      M_Addr      = $urandom;
      M_StoreData = $urandom;
      M_Size      = 2'($urandom);
      M_Unsigned  = 1'($urandom);
      M_MemRead   = 1'($urandom);
      M_MemWrite  = 1'($urandom);
      dmem_ack    = (w == waits);
      dmem_rdata  = (w == waits) ? rdat : $urandom;
      @(negedge clock);
    end
    dmem_ack = 1'b0;
    if (!wr) exp_mem = ref_load(sz, uns, a, rdat);
    chk("done_stall", mem_stall, 0);
    chk("done_req", dmem_req, 0);
    chk("done_be", dmem_be, 0);
    chk("done_memdata", M_MemData, exp_mem);
    chk("done_buserr", M_BusErr, 0);
    chk("stall_cycles", stalls, 2 + waits);
    M_MemRead  = 1'b0;
    M_MemWrite = 1'b0;
    @(negedge clock);
    #1;
    chk("idle_stall", mem_stall, 0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    reset = 1'b1;
    M_MemRead = 1'b1; M_MemWrite = 1'b0; M_Size = 2'b10; M_Unsigned = 1'b0;
    M_Addr = 32'h0; M_StoreData = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    exp_mem = 32'h0;
    repeat (2) @(negedge clock);
    chk("rst_stall", mem_stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_memdata", M_MemData, 0);
    chk("rst_buserr", M_BusErr, 0);
    M_MemRead = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // Aligned word load, immediate ack.
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 0);
    chk("tp_word_load", M_MemData, 32'h1234_5678);
    // Byte load at lane 3, signed then unsigned.
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 0);
    chk("tp_byte_signed", M_MemData, 32'hFFFF_FF80);
    run_access(1'b0, 1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 1);
    chk("tp_byte_unsigned", M_MemData, 32'h0000_0080);
    // Half store, three wait cycles; both controls high means store.
    run_access(1'b1, 1'b1, 2'b01, 1'b0, 32'h22, 32'hAAAA_BEEF, 32'h5555_5555, 3);
    chk("tp_half_store_keeps", M_MemData, 32'h0000_0080);

    // Misaligned word load.
    M_MemRead = 1'b1; M_MemWrite = 1'b0; M_Size = 2'b10; M_Addr = 32'h102;
    #1;
    chk("mis_addrerr", M_AddrErr, 1);
    chk("mis_stall", mem_stall, 0);
    @(negedge clock);
    chk("mis_req", dmem_req, 0);
    chk("mis_memdata", M_MemData, exp_mem);
    M_Size = 2'b01; M_Addr = 32'h101;
    #1;
    chk("mis_half_addrerr", M_AddrErr, 1);
    M_MemRead = 1'b0;
    #1;
    chk("no_op_addrerr", M_AddrErr, 0);

    // Stray ack while idle is ignored.
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    dmem_ack = 1'b0;
    chk("stray_ack_req", dmem_req, 0);
    chk("stray_ack_memdata", M_MemData, exp_mem);

    // Randomized accesses (waits kept below the timeout so the ack always wins).
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom);
      a  = $urandom;
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz[1]) a[1:0] = 2'b00;
      run_access(1'($urandom_range(0, 2) == 0), 1'b1, sz, 1'($urandom), a,
                 $urandom, $urandom, $urandom_range(0, TB_TIMEOUT - 1));
    end

    // Reset in the second ACCESS cycle; the late ack must be ignored.
    M_MemRead = 1'b1; M_Size = 2'b10; M_Addr = 32'h200;
    @(negedge clock);
    M_MemRead = 1'b0;
    chk("rstmid_req1", dmem_req, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rstmid_stall_in_reset", mem_stall, 0);
    @(negedge clock);
    reset = 1'b0;
    exp_mem = 32'h0;
    chk("rstmid_req", dmem_req, 0);
    chk("rstmid_memdata", M_MemData, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    #1;
    chk("rstmid_stall", mem_stall, 0);
    @(negedge clock);
    dmem_ack = 1'b0;
    chk("rstmid_ack_req", dmem_req, 0);
    chk("rstmid_ack_memdata", M_MemData, 0);

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      n = 0;
      M_MemRead = 1'b1; M_Size = 2'b10; M_Addr = 32'h40;
      @(negedge clock);
      M_MemRead = 1'b0;
      while (dmem_req && n < 20) begin
        n++;
        @(negedge clock);
      end
      exp_mem = 32'hDEAD_BEEF;
      chk("to_req_cycles", n, TB_TIMEOUT);
      chk("to_buserr", M_BusErr, 1);
      chk("to_memdata", M_MemData, exp_mem);
      chk("to_stall", mem_stall, 0);
      @(negedge clock);
      chk("to_buserr_pulse", M_BusErr, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
